dbus_rr_arbiter: RTL and testbench

DBUS_RR_ARBITER -- requirements
Module: dbus_rr_arbiter

---
 rtl/dbus_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dbus_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter folding NREQ dbus requesters onto one downstream dbus
// port. Only one transaction is in flight downstream at a time. Issue is
// zero-latency from IDLE, and the grant is held in BUSY until data_ok.
//
// Handshake: a requester raises valid with a stable payload and keeps both
// until it sees its own data_ok. Downstream, oreq.valid is held with a stable
// payload until oresp.data_ok. A cycle with oreq.valid && oresp.data_ok
// completes the transaction. addr_ok is not used as a separate phase;
// upstream it mirrors data_ok.

package dbus_rr_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

module dbus_rr_arbiter
  import dbus_rr_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  dbus_req_t [NREQ-1:0] ireq,
  output dbus_resp_t [NREQ-1:0] iresp,
  output dbus_req_t            oreq,
  input  dbus_resp_t           oresp,
  output logic                 busy,
  output logic [IW-1:0]        owner,
  output logic [31:0]          txn_count,
  output state_t               dbg_state,
  output logic [IW-1:0]        dbg_ptr
);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  dbus_req_t       saved_req_q, saved_req_d;
  logic [31:0]     txn_count_q;

  logic            found;
  logic [IW-1:0]   sel;
  logic            done;
  logic [IW-1:0]   done_idx;

  // Downstream addr_ok has no role: completion is signalled by data_ok alone.
  logic            unused_addr_ok;
  assign unused_addr_ok = oresp.addr_ok;

  // Advance an index by one, wrapping NREQ-1 back to 0.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    else                    return v + IW'(1);
  endfunction

  // Pick the first valid requester, starting at ptr and wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && ireq[idx].valid) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next state, downstream request, and completion routing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    saved_req_d = saved_req_q;
    oreq        = '0;
    owner       = '0;
    done        = 1'b0;
    done_idx    = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          oreq  = ireq[sel];
          owner = sel;
          if (oresp.data_ok) begin
            done     = 1'b1;
            done_idx = sel;
            ptr_d    = wrap_inc(sel);
          end else begin
            state_d     = BUSY;
            saved_req_d = ireq[sel];
            owner_d     = sel;
          end
        end
      end
      BUSY: begin
        // The latched copy is replayed so upstream changes cannot leak through.
        oreq  = saved_req_q;
        owner = owner_q;
        if (oresp.data_ok) begin
          done     = 1'b1;
          done_idx = owner_q;
          ptr_d    = wrap_inc(owner_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset suppresses issue and completion; a BUSY transaction is dropped.
    if (!reset) begin
      oreq.valid = 1'b0;
      owner      = '0;
      done       = 1'b0;
    end
  end

  // Upstream responses: data broadcast, data_ok/addr_ok only to the owner.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      iresp[i].data    = oresp.data;
      iresp[i].data_ok = done && (done_idx == IW'(i));
      iresp[i].addr_ok = done && (done_idx == IW'(i));
    end
  end

  // State register, round-robin pointer, latched request and counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      saved_req_q <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      saved_req_q <= saved_req_d;
      if (done) txn_count_q <= txn_count_q + 32'd1;
    end
  end

  assign busy      = (state_q == BUSY);
  assign txn_count = txn_count_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Directed bench for dbus_rr_arbiter with NREQ=4: a table of per-cycle
// vectors plus hand sequences for payload hold, reset-in-BUSY and counter wrap.
// Requester i always presents addr = i*0x100 and wdata = 0xA0+i, except where
// a sequence deliberately changes it.

module tb_dbus_rr_arbiter;
  import dbus_rr_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic                  clk;
  logic                  reset;
  dbus_req_t [NREQ-1:0]  ireq;
  dbus_resp_t [NREQ-1:0] iresp;
  dbus_req_t             oreq;
  dbus_resp_t            oresp;
  logic                  busy;
  logic [IW-1:0]         owner;
  logic [31:0]           txn_count;
  state_t                dbg_state;
  logic [IW-1:0]         dbg_ptr;

  int n_vec  = 0;
  int n_miss = 0;

  logic [IW-1:0] exp_q[$];

  typedef struct {
    logic          rst;
    logic [3:0]    vm;
    logic          dok;
    logic [31:0]   rd;
    logic          e_valid;
    logic [IW-1:0] e_owner;
    logic          e_busy;
    logic [3:0]    e_dok;
    logic [31:0]   e_cnt;
    logic [IW-1:0] e_ptr;
  } vec_t;

  vec_t tbl[$];

  dbus_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iresp     (iresp),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .owner     (owner),
    .txn_count (txn_count),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- helpers ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] vm, input logic dok,
                              input logic [31:0] rd, input logic e_valid,
                              input logic [IW-1:0] e_owner, input logic e_busy,
                              input logic [3:0] e_dok, input logic [31:0] e_cnt,
                              input logic [IW-1:0] e_ptr);
    vec_t v;
    v.rst = rst; v.vm = vm; v.dok = dok; v.rd = rd;
    v.e_valid = e_valid; v.e_owner = e_owner; v.e_busy = e_busy;
    v.e_dok = e_dok; v.e_cnt = e_cnt; v.e_ptr = e_ptr;
    return v;
  endfunction

  // ---- driver ----
  task automatic drive(input logic rst, input logic [3:0] vm, input logic dok, input logic [31:0] rd);
    reset = rst;
    for (int i = 0; i < NREQ; i++) ireq[i].valid = vm[i];
    oresp.data_ok = dok;
    oresp.addr_ok = dok;
    oresp.data    = rd;
  endtask

  // Compare every observable against hand-computed expectations for this cycle.
  task automatic check_obs(input string tag, input logic e_valid, input logic [IW-1:0] e_owner,
                           input logic e_busy, input logic [3:0] e_dok, input logic [31:0] e_cnt,
                           input logic [IW-1:0] e_ptr, input logic [31:0] rd);
    logic [3:0] dm;
    logic [3:0] am;
    logic       data_bad;
    data_bad = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dm[i] = iresp[i].data_ok;
      am[i] = iresp[i].addr_ok;
      if (iresp[i].data !== rd) data_bad = 1'b1;
    end
    check({tag, " oreq.valid"}, 32'(oreq.valid), 32'(e_valid));
    if (e_valid) begin
      check({tag, " oreq.addr"}, oreq.addr, 32'h100 * 32'(e_owner));
      check({tag, " oreq.wdata"}, oreq.wdata, 32'hA0 + 32'(e_owner));
    end
    check({tag, " owner"}, 32'(owner), 32'(e_owner));
    check({tag, " busy"}, 32'(busy), 32'(e_busy));
    check({tag, " data_ok"}, 32'(dm), 32'(e_dok));
    check({tag, " addr_ok"}, 32'(am), 32'(e_dok));
    check({tag, " txn_count"}, txn_count, e_cnt);
    check({tag, " ptr"}, 32'(dbg_ptr), 32'(e_ptr));
    check({tag, " data_bcast"}, 32'(data_bad), 32'd0);
  endtask

  // ---- scoreboard: completion order against the expected owner queue ----
  always @(negedge clk) begin
    logic [3:0]    m;
    logic [IW-1:0] got;
    logic [IW-1:0] want;
    got = '0;
    for (int i = 0; i < NREQ; i++) begin
      m[i] = iresp[i].data_ok;
      if (iresp[i].data_ok) got = IW'(i);
    end
    if (m != 4'b0000) begin
      check("one_hot_data_ok", 32'($countones(m)), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'(got), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check("completion_order", 32'(got), 32'(want));
      end
    end
  end

  // ---- stimulus ----
  initial begin
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ireq[i].valid = 1'b0;
      ireq[i].wr    = 1'b1;
      ireq[i].wstrb = 4'hF;
      ireq[i].addr  = 32'h100 * i;
      ireq[i].wdata = 32'hA0 + i;
    end
    oresp = '0;
    @(posedge clk);
    #1;

    //                rst vm      dok rd            val own bsy dok     cnt    ptr
    tbl.push_back(mk(0, 4'b1111, 1, 32'hD000_0000, 0, 0, 0, 4'b0000, 32'd0, 0)); // reset forces outputs off
    tbl.push_back(mk(1, 4'b0100, 1, 32'hD000_0001, 1, 2, 0, 4'b0100, 32'd0, 0)); // single-cycle grant to 2
    tbl.push_back(mk(1, 4'b0000, 0, 32'hD000_0002, 0, 0, 0, 4'b0000, 32'd1, 3)); // ptr=3, count=1
    tbl.push_back(mk(1, 4'b1000, 1, 32'hD000_0003, 1, 3, 0, 4'b1000, 32'd1, 3)); // grant 3
    tbl.push_back(mk(1, 4'b0001, 1, 32'hD000_0004, 1, 0, 0, 4'b0001, 32'd2, 0)); // ptr wrapped, grant 0
    tbl.push_back(mk(1, 4'b0000, 0, 32'hD000_0005, 0, 0, 0, 4'b0000, 32'd3, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 32'hD000_0006, 0, 0, 0, 4'b0000, 32'd3, 1)); // reset again
    // all four valid, two busy cycles per grant: order 0,1,2,3,0
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_0007, 1, 0, 0, 4'b0000, 32'd0, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_0008, 1, 0, 1, 4'b0000, 32'd0, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 32'hD000_0009, 1, 0, 1, 4'b0001, 32'd0, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_000A, 1, 1, 0, 4'b0000, 32'd1, 1));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_000B, 1, 1, 1, 4'b0000, 32'd1, 1));
    tbl.push_back(mk(1, 4'b1111, 1, 32'hD000_000C, 1, 1, 1, 4'b0010, 32'd1, 1));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_000D, 1, 2, 0, 4'b0000, 32'd2, 2));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_000E, 1, 2, 1, 4'b0000, 32'd2, 2));
    tbl.push_back(mk(1, 4'b1111, 1, 32'hD000_000F, 1, 2, 1, 4'b0100, 32'd2, 2));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_0010, 1, 3, 0, 4'b0000, 32'd3, 3));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_0011, 1, 3, 1, 4'b0000, 32'd3, 3));
    tbl.push_back(mk(1, 4'b1111, 1, 32'hD000_0012, 1, 3, 1, 4'b1000, 32'd3, 3));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_0013, 1, 0, 0, 4'b0000, 32'd4, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 32'hD000_0014, 1, 0, 1, 4'b0000, 32'd4, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 32'hD000_0015, 1, 0, 1, 4'b0001, 32'd4, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 32'hD000_0016, 0, 0, 0, 4'b0000, 32'd5, 1)); // five completions
    // owner drops valid while BUSY: transaction still completes
    tbl.push_back(mk(1, 4'b0100, 0, 32'hD000_0017, 1, 2, 0, 4'b0000, 32'd5, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 32'hD000_0018, 1, 2, 1, 4'b0000, 32'd5, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 32'hD000_0019, 1, 2, 1, 4'b0100, 32'd5, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 32'hD000_001A, 0, 0, 0, 4'b0000, 32'd6, 3));
    // search wraps past NREQ-1
    tbl.push_back(mk(1, 4'b0011, 1, 32'hD000_001B, 1, 0, 0, 4'b0001, 32'd6, 3));
    tbl.push_back(mk(1, 4'b0011, 1, 32'hD000_001C, 1, 1, 0, 4'b0010, 32'd7, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 32'hD000_001D, 0, 0, 0, 4'b0000, 32'd8, 2));

    foreach (tbl[n]) begin
      @(posedge clk);
      #1;
      drive(tbl[n].rst, tbl[n].vm, tbl[n].dok, tbl[n].rd);
      for (int i = 0; i < NREQ; i++)
        if (tbl[n].e_dok[i]) exp_q.push_back(IW'(i));
      @(negedge clk);
      check_obs($sformatf("v%0d", n), tbl[n].e_valid, tbl[n].e_owner, tbl[n].e_busy,
                tbl[n].e_dok, tbl[n].e_cnt, tbl[n].e_ptr, tbl[n].rd);
    end

    // Owner 1 changes its address mid-wait; downstream must keep the latched one.
    @(posedge clk); #1;
    drive(1, 4'b0010, 0, 32'h0);
    @(negedge clk);
    check_obs("hold_issue", 1, 1, 0, 4'b0000, 32'd8, 2, 32'h0);
    @(posedge clk); #1;
    ireq[1].addr = 32'h200;
    drive(1, 4'b0010, 0, 32'h0);
    @(negedge clk);
    check_obs("hold_wait1", 1, 1, 1, 4'b0000, 32'd8, 2, 32'h0);
    @(posedge clk); #1;
    drive(1, 4'b0010, 0, 32'h0);
    @(negedge clk);
    check_obs("hold_wait2", 1, 1, 1, 4'b0000, 32'd8, 2, 32'h0);
    @(posedge clk); #1;
    drive(1, 4'b0010, 1, 32'hCAFE_F00D);
    exp_q.push_back(IW'(1));
    @(negedge clk);
    check_obs("hold_done", 1, 1, 1, 4'b0010, 32'd8, 2, 32'hCAFE_F00D);
    check("hold_resp_data", iresp[1].data, 32'hCAFE_F00D);

    // Reset pulled while owner 3 is outstanding: no completion, restart at 0.
    @(posedge clk); #1;
    ireq[1].addr = 32'h100;
    drive(1, 4'b1000, 0, 32'h0);
    @(negedge clk);
    check_obs("rstbusy_issue", 1, 3, 0, 4'b0000, 32'd9, 2, 32'h0);
    @(posedge clk); #1;
    drive(1, 4'b1000, 0, 32'h0);
    @(negedge clk);
    check_obs("rstbusy_wait", 1, 3, 1, 4'b0000, 32'd9, 2, 32'h0);
    @(posedge clk); #1;
    drive(0, 4'b1000, 1, 32'h1234);
    @(negedge clk);
    check_obs("rstbusy_reset", 0, 0, 1, 4'b0000, 32'd9, 2, 32'h1234);
    @(posedge clk); #1;
    drive(1, 4'b1111, 0, 32'h0);
    @(negedge clk);
    check_obs("rstbusy_after", 1, 0, 0, 4'b0000, 32'd0, 0, 32'h0);
    @(posedge clk); #1;
    drive(1, 4'b1111, 1, 32'h5);
    exp_q.push_back(IW'(0));
    @(negedge clk);
    check_obs("rstbusy_done", 1, 0, 1, 4'b0001, 32'd0, 0, 32'h5);

    // Counter wrap from all-ones, arbitration carries on normally.
    @(posedge clk); #1;
    force dut.txn_count_q = 32'hFFFF_FFFF;
    drive(1, 4'b0100, 1, 32'h6);
    exp_q.push_back(IW'(2));
    #1;
    release dut.txn_count_q;
    @(negedge clk);
    check_obs("wrap_pre", 1, 2, 0, 4'b0100, 32'hFFFF_FFFF, 1, 32'h6);
    @(posedge clk); #1;
    drive(1, 4'b1111, 1, 32'h7);
    exp_q.push_back(IW'(3));
    @(negedge clk);
    check_obs("wrap_post", 1, 3, 0, 4'b1000, 32'd0, 3, 32'h7);
    @(posedge clk); #1;
    drive(1, 4'b0000, 0, 32'h0);
    @(negedge clk);
    check_obs("wrap_idle", 0, 0, 0, 4'b0000, 32'd1, 0, 32'h0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
